// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file arbiter.
package regfile_pkg;

   localparam int ADDR_W       = 4;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 8;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_RESP
   } arb_state_t;

endpackage

// File: rtl/regfile_starve_timer.sv
// Saturating count of cycles a debug request has waited; flags when the limit is reached.
module regfile_starve_timer #(
   parameter int LIMIT = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_at_limit
);

   localparam int CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_at_limit = (r_cnt == CNT_W'(LIMIT));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !o_at_limit) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the register-file ports between the core pipeline (priority) and a debug port,
// with starvation forcing, write bypass for debug reads and a hardwired-zero x0.
module regfile_arbiter
   import regfile_pkg::*;
#(
   parameter int ADDR_W       = regfile_pkg::ADDR_W,
   parameter int DATA_W       = regfile_pkg::DATA_W,
   parameter int STARVE_LIMIT = regfile_pkg::STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_rd_en,
   input  logic [ADDR_W-1:0] core_rs1adr,
   input  logic [ADDR_W-1:0] core_rs2adr,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_rdadr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rs1,
   output logic [DATA_W-1:0] core_rs2,
   output logic              core_stall,
   input  logic              dbg_valid,
   output logic              dbg_ready,
   input  logic              dbg_write,
   input  logic [ADDR_W-1:0] dbg_adr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_rvalid,
   input  logic              dbg_rready,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              rf_regwrite,
   output logic [ADDR_W-1:0] rf_rdadr,
   output logic [DATA_W-1:0] rf_rd,
   output logic [ADDR_W-1:0] rf_rs1adr,
   output logic [ADDR_W-1:0] rf_rs2adr,
   input  logic [DATA_W-1:0] rf_rs1,
   input  logic [DATA_W-1:0] rf_rs2
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              w_at_limit;
   logic              w_idle_req;
   logic              w_grant;
   logic              w_forced;
   logic              w_accept;
   logic              w_rd_accept;
   logic              w_sel_we;
   logic              r_byp;
   logic [DATA_W-1:0] r_byp_data;
   logic [ADDR_W-1:0] r_rd_adr;

   assign core_rs1 = rf_rs1;
   assign core_rs2 = rf_rs2;

   // Gating with reset keeps every handshake quiet while reset is held.
   assign w_idle_req  = reset && (r_state == IDLE) && dbg_valid;
   assign w_grant     = w_idle_req && (dbg_write ? !core_we : !core_rd_en);
   assign w_forced    = w_idle_req && !w_grant && w_at_limit;
   assign w_accept    = w_grant || w_forced;
   assign w_rd_accept = w_accept && !dbg_write;
   assign dbg_ready   = w_accept;
   assign core_stall  = w_forced;

   regfile_starve_timer #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_timer (
      .clk        (clk),
      .reset      (reset),
      .i_inc      ((r_state == IDLE) && dbg_valid && !dbg_ready),
      .i_clr      (w_accept),
      .o_at_limit (w_at_limit)
   );

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      rf_rs1adr = core_rs1adr;
      rf_rs2adr = core_rs2adr;
      rf_rdadr  = core_rdadr;
      rf_rd     = core_wdata;
      w_sel_we  = core_we && !w_forced;
      if (w_rd_accept) begin
         rf_rs1adr = dbg_adr;
         rf_rs2adr = dbg_adr;
      end
      if (w_accept && dbg_write) begin
         rf_rdadr = dbg_adr;
         rf_rd    = dbg_wdata;
         w_sel_we = 1'b1;
      end
      rf_regwrite = reset && w_sel_we && (rf_rdadr != '0);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_rd_accept) w_state_nxt = RD_WAIT;
         RD_WAIT: w_state_nxt = RD_RESP;
         RD_RESP: if (dbg_rready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // NOTE: the read-data registers are reset too, so a dropped read leaves no stale value visible.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_byp      <= 1'b0;
         r_byp_data <= '0;
         r_rd_adr   <= '0;
         dbg_rvalid <= 1'b0;
         dbg_rdata  <= '0;
      end else begin
         if (w_rd_accept) begin
            r_byp      <= rf_regwrite && (rf_rdadr == dbg_adr);
            r_byp_data <= rf_rd;
            r_rd_adr   <= dbg_adr;
         end
         if (r_state == RD_WAIT) begin
            dbg_rvalid <= 1'b1;
            dbg_rdata  <= (r_rd_adr == '0) ? '0 : (r_byp ? r_byp_data : rf_rs1);
         end else if ((r_state == RD_RESP) && dbg_rready) begin
            dbg_rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a behavioural 16x32 register file, a read-data
// scoreboard with an independent monitor, and direct checks on handshakes and muxing.
module tb_regfile_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_rd_en;
   logic [3:0]  core_rs1adr, core_rs2adr, core_rdadr;
   logic        core_we;
   logic [31:0] core_wdata;
   logic [31:0] core_rs1, core_rs2;
   logic        core_stall;
   logic        dbg_valid, dbg_ready, dbg_write;
   logic [3:0]  dbg_adr;
   logic [31:0] dbg_wdata;
   logic        dbg_rvalid, dbg_rready;
   logic [31:0] dbg_rdata;
   logic        rf_regwrite;
   logic [3:0]  rf_rdadr, rf_rs1adr, rf_rs2adr;
   logic [31:0] rf_rd, rf_rs1, rf_rs2;

   int n_pass  = 0;
   int n_total = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   regfile_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .core_rd_en  (core_rd_en),
      .core_rs1adr (core_rs1adr),
      .core_rs2adr (core_rs2adr),
      .core_we     (core_we),
      .core_rdadr  (core_rdadr),
      .core_wdata  (core_wdata),
      .core_rs1    (core_rs1),
      .core_rs2    (core_rs2),
      .core_stall  (core_stall),
      .dbg_valid   (dbg_valid),
      .dbg_ready   (dbg_ready),
      .dbg_write   (dbg_write),
      .dbg_adr     (dbg_adr),
      .dbg_wdata   (dbg_wdata),
      .dbg_rvalid  (dbg_rvalid),
      .dbg_rready  (dbg_rready),
      .dbg_rdata   (dbg_rdata),
      .rf_regwrite (rf_regwrite),
      .rf_rdadr    (rf_rdadr),
      .rf_rd       (rf_rd),
      .rf_rs1adr   (rf_rs1adr),
      .rf_rs2adr   (rf_rs2adr),
      .rf_rs1      (rf_rs1),
      .rf_rs2      (rf_rs2)
   );

   // Register file model; x0 holds garbage so the arbiter's zero-forcing is visible.
   logic [31:0] mem [16];
   logic        mem_loaded = 1'b0;
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h7777_0000 + i;
         mem[0]     <= 32'hBAD0_BAD0;
         mem_loaded <= 1'b1;
      end else if (rf_regwrite) begin
         mem[rf_rdadr] <= rf_rd;
      end
      rf_rs1 <= mem[rf_rs1adr];
      rf_rs2 <= mem[rf_rs2adr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // Monitor: every consumed debug read is compared against the oldest expectation.
   always @(negedge clk) begin
      if (reset && dbg_rvalid && dbg_rready) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_rvalid: got rdata 0x%08h expected no response", dbg_rdata);
         end else begin
            check("rdata", dbg_rdata, exp_q.pop_front());
         end
      end
   end

   task automatic do_write(input logic [3:0] adr, input logic [31:0] data, input logic exp_we);
      dbg_valid = 1'b1; dbg_write = 1'b1; dbg_adr = adr; dbg_wdata = data;
      @(negedge clk);
      check("wr_ready", dbg_ready, 1);
      check("wr_regwrite", rf_regwrite, exp_we);
      check("wr_data", rf_rd, data);
      @(posedge clk); #1;
      dbg_valid = 1'b0; dbg_write = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] adr, input logic [31:0] exp, input logic exp_we);
      dbg_valid = 1'b1; dbg_write = 1'b0; dbg_adr = adr;
      @(negedge clk);
      check("rd_ready", dbg_ready, 1);
      check("rd_rs1adr", rf_rs1adr, adr);
      check("rd_regwrite", rf_regwrite, exp_we);
      exp_q.push_back(exp);
      @(posedge clk); #1;
      dbg_valid = 1'b0;
      @(negedge clk);
      check("rd_wait_rvalid", dbg_rvalid, 0);
      @(negedge clk);
      check("rd_resp_rvalid", dbg_rvalid, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int waited;
      bit got;
      reset = 1'b0;
      core_rd_en = 1'b0; core_rs1adr = 4'd1; core_rs2adr = 4'd2;
      core_we = 1'b1; core_rdadr = 4'd3; core_wdata = 32'h3333_3333;
      dbg_valid = 1'b1; dbg_write = 1'b0; dbg_adr = 4'd5; dbg_wdata = '0;
      dbg_rready = 1'b1;
      #12;
      check("rst_stall", core_stall, 0);
      check("rst_ready", dbg_ready, 0);
      check("rst_regwrite", rf_regwrite, 0);
      check("rst_rvalid", dbg_rvalid, 0);
      check("rst_rdata", dbg_rdata, 0);
      dbg_valid = 1'b0; core_we = 1'b0;
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;

      // Write x5 then read it back with an idle core.
      do_write(4'd5, 32'hDEAD_BEEF, 1'b1);
      do_read(4'd5, 32'hDEAD_BEEF, 1'b0);

      // x0 is never written and always reads zero.
      do_write(4'd0, 32'h0000_1234, 1'b0);
      do_read(4'd0, 32'h0, 1'b0);

      // Core write to x7 in the same cycle as the debug read of x7.
      core_we = 1'b1; core_rdadr = 4'd7; core_wdata = 32'hA5A5_A5A5;
      do_read(4'd7, 32'hA5A5_A5A5, 1'b1);
      core_we = 1'b0;

      // Response held for 5 cycles with a new request pending.
      dbg_rready = 1'b0;
      dbg_valid = 1'b1; dbg_write = 1'b0; dbg_adr = 4'd7;
      @(negedge clk);
      check("hold_accept", dbg_ready, 1);
      exp_q.push_back(32'hA5A5_A5A5);
      @(negedge clk);
      check("hold_wait_ready", dbg_ready, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("hold_rvalid", dbg_rvalid, 1);
         check("hold_rdata", dbg_rdata, 32'hA5A5_A5A5);
         check("hold_ready", dbg_ready, 0);
      end
      @(posedge clk); #1;
      dbg_valid = 1'b0; dbg_rready = 1'b1;
      @(posedge clk); #1;

      // Starvation: core reads every cycle, debug forced in after 8 waiting cycles.
      core_rd_en = 1'b1; core_we = 1'b1; core_rdadr = 4'd9; core_wdata = 32'h0000_0099;
      dbg_valid = 1'b1; dbg_write = 1'b0; dbg_adr = 4'd5;
      waited = 0; got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (dbg_ready) begin
            got = 1'b1;
            break;
         end
         check("starve_stall_low", core_stall, 0);
         waited++;
         @(posedge clk); #1;
      end
      check("starve_granted", got, 1);
      check("starve_wait_cycles", waited, 8);
      check("forced_stall", core_stall, 1);
      check("forced_core_we_suppressed", rf_regwrite, 0);
      check("forced_rs2adr", rf_rs2adr, 4'd5);
      exp_q.push_back(32'hDEAD_BEEF);
      @(posedge clk); #1;
      dbg_valid = 1'b0;
      @(negedge clk);
      check("post_forced_stall", core_stall, 0);
      @(negedge clk);
      check("forced_rvalid", dbg_rvalid, 1);
      @(posedge clk); #1;
      core_rd_en = 1'b0; core_we = 1'b0;

      // Reset while the read is in RD_WAIT drops the transaction.
      dbg_valid = 1'b1; dbg_write = 1'b0; dbg_adr = 4'd5;
      @(negedge clk);
      check("rstmid_accept", dbg_ready, 1);
      @(posedge clk); #1;
      core_we = 1'b1; core_rdadr = 4'd4; core_wdata = 32'h4444_4444;
      #2 reset = 1'b0;
      #1;
      check("rstmid_rvalid", dbg_rvalid, 0);
      check("rstmid_rdata", dbg_rdata, 0);
      check("rstmid_ready", dbg_ready, 0);
      check("rstmid_stall", core_stall, 0);
      check("rstmid_regwrite", rf_regwrite, 0);
      core_we = 1'b0; dbg_valid = 1'b0;
      @(negedge clk) reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("rstmid_no_rvalid", dbg_rvalid, 0);
      end
      @(posedge clk); #1;
      do_read(4'd5, 32'hDEAD_BEEF, 1'b0);

      repeat (2) @(posedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
